// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, horizontal and
// vertical counters, and the sync / active-video / coordinate window decodes.
module vga_sync_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_en,
  output logic             hs,
  output logic             vs,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Window bounds are kept inclusive so every constant fits in CNT_W bits.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_FIRST   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] HA_LAST    = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VA_FIRST   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VA_LAST    = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic             SYNC_LVL   = (SYNC_POL != 0);

  if ((H_TOTAL - 1 > (1 << CNT_W) - 1) || (V_TOTAL - 1 > (1 << CNT_W) - 1)
      || (CLK_DIV < 1)) begin : g_param_check
    $error("vga_sync_gen: CNT_W too narrow for the raster or CLK_DIV < 1");
  end

  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_div_last;
  logic             w_adv;
  logic             w_h_act;
  logic             w_v_act;

  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign w_adv      = en & w_div_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (en) begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  // Horizontal and vertical wraps land on the same edge at the end of a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_adv) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  assign w_h_act = (r_h_cnt >= HA_FIRST) && (r_h_cnt <= HA_LAST);
  assign w_v_act = (r_v_cnt >= VA_FIRST) && (r_v_cnt <= VA_LAST);

  assign pix_en      = w_adv & ~reset;
  assign line_start  = pix_en & (r_h_cnt == '0);
  assign frame_start = line_start & (r_v_cnt == '0);
  assign hs          = (r_h_cnt < H_SYNC_C) ? SYNC_LVL : ~SYNC_LVL;
  assign vs          = (r_v_cnt < V_SYNC_C) ? SYNC_LVL : ~SYNC_LVL;
  assign active      = w_h_act & w_v_act;
  assign x           = active ? (r_h_cnt - HA_FIRST) : '0;
  assign y           = active ? (r_v_cnt - VA_FIRST) : '0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance stepped to chosen
// raster points, plus a tiny active-high, divide-by-1 instance checked per pixel.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, rst1, en1;
  logic       pix_en0, hs0, vs0, active0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pix_en1, hs1, vs1, active1, ls1, fs1;
  logic [3:0] x1, y1;

  int n_vec = 0;
  int n_err = 0;
  int k_cnt = 0;

  vga_sync_gen dut0 (
    .clk(clk), .reset(rst0), .en(en0), .pix_en(pix_en0), .hs(hs0), .vs(vs0),
    .active(active0), .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  vga_sync_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .CNT_W(4), .CLK_DIV(1), .SYNC_POL(1)
  ) dut1 (
    .clk(clk), .reset(rst1), .en(en1), .pix_en(pix_en1), .hs(hs1), .vs(vs1),
    .active(active1), .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      $error("miscompare on %s", tag);
    end
  endtask

  // One negedge; k_cnt counts enabled clk edges of dut0 since its reset release.
  task automatic tick0();
    @(negedge clk);
    if (en0) k_cnt++;
  endtask

  // Step dut0 to the given raster point with the divider at phase 0.
  task automatic goto0(input int line, input int h);
    while (k_cnt < 2 * (line * 800 + h)) tick0();
  endtask

  initial begin
    int h, v, hx, vy;
    logic act;
    rst0 = 1'b1; en0 = 1'b1; rst1 = 1'b1; en1 = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_hs", hs0, 0);
    check("rst_vs", vs0, 0);
    check("rst_active", active0, 0);
    check("rst_x", x0, 0);
    check("rst_y", y0, 0);
    check("rst_pix_en", pix_en0, 0);
    check("rst_line_start", ls0, 0);
    check("rst_frame_start", fs0, 0);

    rst0 = 1'b0; k_cnt = 0;
    #1 check("rel_pix_en_0", pix_en0, 0);
    tick0();
    check("first_pix_en", pix_en0, 1);
    check("first_frame_start", fs0, 1);
    check("first_line_start", ls0, 1);
    tick0();
    check("h1_pix_en", pix_en0, 0);
    tick0();
    check("h1_frame_start", fs0, 0);
    check("h1_line_start", ls0, 0);

    goto0(0, 95);  check("hs_h95", hs0, 0);
    goto0(0, 96);  check("hs_h96", hs0, 1);
    goto0(0, 799); check("hs_h799", hs0, 1);
    tick0();       check("h799_line_start", ls0, 0);
    goto0(1, 0);   check("vs_v1", vs0, 0);
    tick0();       check("v1_line_start", ls0, 1);
                   check("v1_frame_start", fs0, 0);
    goto0(2, 0);   check("vs_v2", vs0, 1);

    goto0(35, 143); check("act_h143", active0, 0);
    goto0(35, 144); check("act_h144", active0, 1);
                    check("x_h144", x0, 0);
                    check("y_v35", y0, 0);
    goto0(35, 783); check("act_h783", active0, 1);
                    check("x_h783", x0, 639);
    goto0(35, 784); check("act_h784", active0, 0);
                    check("x_h784", x0, 0);

    goto0(36, 300); check("hold_pre_x", x0, 156);
                    check("hold_pre_y", y0, 1);
    en0 = 1'b0;
    repeat (7) begin
      tick0();
      check("hold_pix_en", pix_en0, 0);
      check("hold_line_start", ls0, 0);
      check("hold_x", x0, 156);
      check("hold_active", active0, 1);
    end
    en0 = 1'b1;
    tick0(); check("resume_pix_en", pix_en0, 1);
             check("resume_x_held", x0, 156);
    tick0(); check("resume_x", x0, 157);

    rst0 = 1'b1;
    #1 check("async_rst_hs", hs0, 0);
    check("async_rst_vs", vs0, 0);
    check("async_rst_active", active0, 0);
    check("async_rst_x", x0, 0);
    check("async_rst_y", y0, 0);
    check("async_rst_pix_en", pix_en0, 0);
    @(negedge clk);
    rst0 = 1'b0; k_cnt = 0;
    tick0(); check("rerel_frame_start", fs0, 1);
             check("rerel_pix_en", pix_en0, 1);
    tick0(); check("rerel_pix_en_off", pix_en0, 0);

    // Small raster: 10 pixels x 6 lines, one pixel per clk, active-high syncs.
    @(negedge clk);
    rst1 = 1'b0;
    for (int n = 0; n < 180; n++) begin
      #1;
      h   = n % 10;
      v   = (n / 10) % 6;
      act = (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
      hx  = act ? h - 4 : 0;
      vy  = act ? v - 2 : 0;
      check("s_pix_en", pix_en1, 1);
      check("s_hs", hs1, (h < 2) ? 1 : 0);
      check("s_vs", vs1, (v < 1) ? 1 : 0);
      check("s_active", active1, act);
      check("s_x", x1, hx);
      check("s_y", y1, vy);
      check("s_line_start", ls1, (h == 0) ? 1 : 0);
      check("s_frame_start", fs1, (h == 0 && v == 0) ? 1 : 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA raster timing generator, the successor to the single `a < b` sync comparator. It owns the horizontal and vertical pixel counters, a pixel-rate clock divider and all window decodes: sync, active video and pixel coordinates. It sits between the system clock and the framebuffer/pixel pipeline and drives the VGA connector's HS/VS pins directly. Default parameters give 640x480@60 from a 50 MHz clock.

## Interface
- `H_SYNC`, 96: horizontal sync width (pixels)
- `H_BACK`, 48: horizontal back porch
- `H_ACTIVE`, 640: horizontal visible pixels
- `H_FRONT`, 16: horizontal front porch
- `V_SYNC`, 2: vertical sync width (lines)
- `V_BACK`, 33 / `V_ACTIVE`, 480 / `V_FRONT`, 10: vertical segments
- `CNT_W`, 10: counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- `CLK_DIV`, 2: clk cycles per pixel, ≥1
- `SYNC_POL`, 0: 0 = sync pulses active-low, 1 = active-high
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `en`  in  1  run enable; low freezes divider and counters
- `pix_en`  out  1  one-clk strobe marking a pixel advance
- `hs`  out  1  horizontal sync, polarity per SYNC_POL
- `vs`  out  1  vertical sync, polarity per SYNC_POL
- `active`  out  1  inside visible region
- `x`  out  CNT_W  visible column, 0 when not active
- `y`  out  CNT_W  visible row, 0 when not active
- `line_start`  out  1  pix_en strobe at h_cnt==0
- `frame_start`  out  1  pix_en strobe at h_cnt==0 and v_cnt==0

## Operation
- Derived constants: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (800); V_TOTAL likewise (525). Segment order in each line/frame: sync, back porch, active, front porch. Count 0 is the first sync pixel.
- Divider `div_cnt` counts 0..CLK_DIV-1 while `en` is high. `pix_en` = en & (div_cnt==CLK_DIV-1) & ~reset. For CLK_DIV=1, div_cnt stays 0 and pix_en = en.
- On a clk edge with pix_en high:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt is at V_TOTAL-1 and h wraps, v_cnt wraps to 0.
- Decodes are combinational from the registered counters:
  - hs asserted when h_cnt < H_SYNC; vs asserted when v_cnt < V_SYNC. Asserted level = SYNC_POL; deasserted = ~SYNC_POL.
  - active = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and v_cnt in the equivalent vertical window.
  - x = h_cnt-(H_SYNC+H_BACK) and y = v_cnt-(V_SYNC+V_BACK) when active, else both 0.
- Width rule: all compares are unsigned CNT_W-bit. An elaboration-time check fails if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1.
- Reset (asynchronous, any time including mid-frame): div_cnt=0, h_cnt=0, v_cnt=0 immediately.
  - Resulting outputs: hs=vs=SYNC_POL, active=0, x=y=0, pix_en=line_start=frame_start=0.
  - After release, the first pix_en occurs CLK_DIV clk edges later and starts a clean frame.
- `en` low: div_cnt, h_cnt and v_cnt hold; decodes keep reflecting the held counts; strobes stay 0. Resuming continues exactly where it stopped.

## Timing
- Pixel period = CLK_DIV clk cycles. Line = H_TOTAL pixels; frame = H_TOTAL·V_TOTAL pixels (420000 pixels = 840000 clk at defaults).
- Counter values change on the edge where pix_en was high. hs/vs/active/x/y follow in the same cycle (zero added latency from the counter).
- line_start and frame_start are coincident with the pix_en that *begins* the advance away from count 0. Each is exactly one clk wide.
- The last line's wrap and the frame wrap happen on the same edge; there is no intermediate state.

## Test plan
- Reset defaults: assert reset mid-run → hs=0, vs=0, active=0, x=y=0 asynchronously. Release → first pix_en on the 2nd clk edge; frame_start=1 with it.
- Horizontal window: defaults, run one line → hs low for h_cnt 0..95, high 96..799. active rises at h_cnt 144 with x=0, x=639 at h_cnt 783, active=0 at 784.
- Wraps: h_cnt 799 → 0 with v_cnt +1. At v=524,h=799 the next pix_en gives v=0,h=0 and a frame_start pulse. vs low only for v 0..1; y=479 at v=514.
- Enable hold: drop en for 7 clk at h_cnt=300 → counters and outputs frozen, no strobes. Re-raise → h_cnt 301 after 2 clk.
- SYNC_POL=1, CLK_DIV=1: hs high for h 0..95; pix_en every clk; frame period 420000 clk.
- Small config (H_TOTAL=10, V_TOTAL=6, CNT_W=4): full-frame scoreboard against a reference counter model for 3 frames.
